// File: rtl/gol_gen_scheduler_pkg.sv
// Shared constants, FSM encoding and cell addressing for the Game of Life scheduler.
package gol_pkg;

  localparam int BOARD_N = 16;
  localparam int ROW_W   = 16;
  localparam int CELLS   = BOARD_N * ROW_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMPUTE,
    ST_COMMIT
  } state_t;

  // Flat bit index of cell (r,c) in the 256-bit board vector (r*16 + c).
  function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [3:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/gol_gen_scheduler_if.sv
// Command/status bundle between the user-control side and the generation scheduler.
interface gol_gen_scheduler_if;
  import gol_pkg::*;

  logic                   run_toggle_i;
  logic                   step_i;
  logic                   clear_i;
  logic                   load_i;
  logic [3:0]             row_sel_i;
  logic [ROW_W-1:0]       row_data_i;
  logic [1:0]             speed_i;
  logic [CELLS-1:0]       board_o;
  logic [15:0]            generation_o;
  logic                   running_o;
  logic                   busy_o;
  logic                   gen_done_o;

  // Command source (user controls / bench).
  modport master (
    output run_toggle_i, step_i, clear_i, load_i, row_sel_i, row_data_i, speed_i,
    input  board_o, generation_o, running_o, busy_o, gen_done_o
  );

  // Scheduler side.
  modport slave (
    input  run_toggle_i, step_i, clear_i, load_i, row_sel_i, row_data_i, speed_i,
    output board_o, generation_o, running_o, busy_o, gen_done_o
  );

endinterface

// File: rtl/gol_gen_scheduler_row_next.sv
// Combinational next-generation row: each cell looks at its 8 neighbours
// across three rows, with columns wrapping around the board edge.
module gol_row_next
  import gol_pkg::*;
(
  input  logic [ROW_W-1:0] row_up,
  input  logic [ROW_W-1:0] row_cur,
  input  logic [ROW_W-1:0] row_dn,
  output logic [ROW_W-1:0] row_nxt
);

  generate
    for (genvar gi = 0; gi < ROW_W; gi++) begin : g_cell
      localparam int CL = (gi + ROW_W - 1) % ROW_W;
      localparam int CR = (gi + 1) % ROW_W;
      logic [3:0] cnt;

      // Live-neighbour count, 0..8.
      assign cnt = 4'(row_up[CL]) + 4'(row_up[gi]) + 4'(row_up[CR])
                 + 4'(row_cur[CL])                 + 4'(row_cur[CR])
                 + 4'(row_dn[CL]) + 4'(row_dn[gi]) + 4'(row_dn[CR]);

      // Birth on 3, survival on 2 or 3.
      assign row_nxt[gi] = (cnt == 4'd3) | (row_cur[gi] & (cnt == 4'd2));
    end
  endgenerate

endmodule

// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler: owns the board, arbitrates user commands
// against the periodic tick, computes the next board row by row into a shadow
// buffer and commits it in a single cycle.
module gol_gen_scheduler
  import gol_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000
)(
  input  logic                 clk,
  input  logic                 rst_n,
  gol_gen_scheduler_if.slave   bus
);

  localparam int PW = $clog2(TICK_CYCLES + 1);
  localparam logic [PW-1:0] TICK_W = PW'(TICK_CYCLES);

  state_t            state_reg,     state_next;
  logic [CELLS-1:0]  board_reg,     board_next;
  logic [CELLS-1:0]  shadow_reg,    shadow_next;
  logic [15:0]       generation_reg, gen_next;
  logic              running_reg,   running_next;
  logic              gen_done_reg,  gen_done_next;
  logic              tick_reg,      tick_next;
  logic [PW-1:0]     prescaler_reg, prescaler_next;
  logic [3:0]        row_idx_reg,   row_idx_next;

  logic [PW-1:0]     period;
  logic [PW:0]       presc_inc;
  logic [3:0]        row_up_idx, row_dn_idx;
  logic [ROW_W-1:0]  row_new;

  // Tick period shrinks by powers of two with speed; compare is >= so a
  // period drop below the current count fires on the next cycle.
  assign period     = TICK_W >> bus.speed_i;
  assign presc_inc  = {1'b0, prescaler_reg} + {{PW{1'b0}}, 1'b1};

  // Neighbouring rows wrap vertically through 4-bit arithmetic.
  assign row_up_idx = row_idx_reg - 4'd1;
  assign row_dn_idx = row_idx_reg + 4'd1;

  gol_row_next u_row_next (
    .row_up  (board_reg[cell_idx(row_up_idx,  4'd0) +: ROW_W]),
    .row_cur (board_reg[cell_idx(row_idx_reg, 4'd0) +: ROW_W]),
    .row_dn  (board_reg[cell_idx(row_dn_idx,  4'd0) +: ROW_W]),
    .row_nxt (row_new)
  );

  // Next-state and datapath decisions; every target defaults to hold.
  always_comb begin
    state_next     = state_reg;
    board_next     = board_reg;
    shadow_next    = shadow_reg;
    gen_next       = generation_reg;
    running_next   = running_reg;
    prescaler_next = prescaler_reg;
    row_idx_next   = row_idx_reg;
    tick_next      = 1'b0;
    gen_done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.clear_i) begin
          board_next = '0;
          gen_next   = '0;
        end else if (bus.load_i) begin
          board_next[cell_idx(bus.row_sel_i, 4'd0) +: ROW_W] = bus.row_data_i;
        end else if (bus.run_toggle_i) begin
          running_next   = 1'b1;
          prescaler_next = '0;
          state_next     = ST_WAIT;
        end else if (bus.step_i) begin
          row_idx_next = '0;
          state_next   = ST_COMPUTE;
        end
      end

      ST_WAIT: begin
        if (bus.clear_i) begin
          board_next     = '0;
          gen_next       = '0;
          prescaler_next = '0;
        end else if (bus.run_toggle_i) begin
          running_next   = 1'b0;
          prescaler_next = '0;
          state_next     = ST_IDLE;
        end else if (tick_reg) begin
          // Registered tick costs one re-entry cycle before compute starts.
          row_idx_next = '0;
          state_next   = ST_COMPUTE;
        end else if (presc_inc >= {1'b0, period}) begin
          prescaler_next = '0;
          tick_next      = 1'b1;
        end else begin
          prescaler_next = presc_inc[PW-1:0];
        end
      end

      ST_COMPUTE, ST_COMMIT: begin
        if (bus.clear_i) begin
          // Abort: nothing from the half-built shadow survives.
          board_next     = '0;
          shadow_next    = '0;
          gen_next       = '0;
          row_idx_next   = '0;
          prescaler_next = '0;
          state_next     = running_reg ? ST_WAIT : ST_IDLE;
        end else begin
          if (bus.run_toggle_i) begin
            running_next = ~running_reg;
          end
          if (state_reg == ST_COMPUTE) begin
            shadow_next[cell_idx(row_idx_reg, 4'd0) +: ROW_W] = row_new;
            row_idx_next = row_idx_reg + 4'd1;
            if (row_idx_reg == 4'(BOARD_N - 1)) begin
              state_next = ST_COMMIT;
            end
          end else begin
            board_next     = shadow_reg;
            gen_next       = generation_reg + 16'd1;
            gen_done_next  = 1'b1;
            prescaler_next = '0;
            state_next     = running_next ? ST_WAIT : ST_IDLE;
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Board, shadow, counters and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_reg      <= '0;
      shadow_reg     <= '0;
      generation_reg <= '0;
      running_reg    <= 1'b0;
      gen_done_reg   <= 1'b0;
      tick_reg       <= 1'b0;
      prescaler_reg  <= '0;
      row_idx_reg    <= '0;
    end else begin
      board_reg      <= board_next;
      shadow_reg     <= shadow_next;
      generation_reg <= gen_next;
      running_reg    <= running_next;
      gen_done_reg   <= gen_done_next;
      tick_reg       <= tick_next;
      prescaler_reg  <= prescaler_next;
      row_idx_reg    <= row_idx_next;
    end
  end

  assign bus.board_o      = board_reg;
  assign bus.generation_o = generation_reg;
  assign bus.running_o    = running_reg;
  assign bus.busy_o       = (state_reg == ST_COMPUTE) || (state_reg == ST_COMMIT);
  assign bus.gen_done_o   = gen_done_reg;

endmodule

// File: doc/gol_gen_scheduler.md
Name: gol_gen_scheduler

Overview:
- Owns the 16x16 Game of Life board register and sequences every generation update.
- Arbitrates user commands (run/pause, single-step, clear, row load) against the periodic generation tick.
- Computes the next board row by row into a shadow buffer, then commits it atomically.
- Feeds board_o to the VGA renderer and generation_o to the seven-segment generation display.

Parameters:
- TICK_CYCLES, 25_000_000, clk cycles between generations at speed 0 (4 Hz at 100 MHz); bench uses 40.
- BOARD_N, 16, board edge length; fixed at 16 for this revision.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- run_toggle_i  in  1  one-cycle pulse; toggles running/paused.
- step_i  in  1  one-cycle pulse; computes one generation while paused.
- clear_i  in  1  one-cycle pulse; zeroes the board and the generation count.
- load_i  in  1  one-cycle pulse; writes row_data_i into row row_sel_i.
- row_sel_i  in  4  target row for load.
- row_data_i  in  16  row contents; bit c = column c.
- speed_i  in  2  tick period = TICK_CYCLES >> speed_i.
- board_o  out  256  cell (r,c) at bit r*16+c; 1 = alive.
- generation_o  out  16  generations committed since last clear/reset.
- running_o  out  1  high when in RUN mode.
- busy_o  out  1  high in COMPUTE or COMMIT.
- gen_done_o  out  1  one-cycle pulse after each commit.

Behaviour:
- Reset (async, rst_n=0): board_o=0, generation_o=0, running_o=0, busy_o=0, gen_done_o=0, shadow=0, prescaler=0, row index=0, state=IDLE.
- States:
  - IDLE: paused.
  - WAIT: running, prescaler counting.
  - COMPUTE: 16 cycles, row index 0..15.
  - COMMIT: 1 cycle.
- IDLE:
  - clear_i: board and generation go to 0.
  - load_i: board row row_sel_i <= row_data_i on the next edge.
  - run_toggle_i: go to WAIT, running_o=1, prescaler=0.
  - step_i: go to COMPUTE.
  - Priority when simultaneous: clear > load > run_toggle > step.
- WAIT:
  - Prescaler increments each cycle; on reaching (TICK_CYCLES>>speed_i)-1, reset it to 0 and go to COMPUTE.
  - run_toggle_i: go to IDLE, running_o=0.
  - step_i and load_i are ignored.
  - clear_i: zero board and generation, stay in WAIT with prescaler reset to 0.
- COMPUTE:
  - Each cycle, shadow row k <= gol_row_next(board rows k-1, k, k+1); row indices wrap mod 16 (toroidal).
  - Board is unchanged during compute, so every row sees the old generation.
  - After row 15, go to COMMIT.
- COMMIT:
  - board <= shadow; generation_o <= generation_o+1, wrapping 0xFFFF->0x0000; gen_done_o=1 on the following cycle.
  - Next state: WAIT if running_o, else IDLE.
- Latency: step_i sampled at edge E0 gives the new board_o and generation_o after E17; gen_done_o is high for the cycle after E17.
- Commands during COMPUTE or COMMIT:
  - clear_i aborts: next state IDLE (if paused) or WAIT (if running, prescaler=0); board, shadow and generation zeroed; no gen_done_o.
  - run_toggle_i is recorded: running_o flips immediately and the post-commit destination follows the new value.
  - step_i and load_i are dropped.
- Rule: next-state alive iff (alive and 2 or 3 live neighbours) or (dead and exactly 3); 8 neighbours, toroidal in both axes.
- speed_i is sampled continuously. A decrease of the period below the current prescaler value fires the tick on the next cycle (compare is >=).
- Reset mid-COMPUTE returns everything to reset values immediately; no partial commit.

Decomposition:
- Package gol_pkg holds:
  - BOARD_N=16 and ROW_W=16.
  - State encoding (IDLE, WAIT, COMPUTE, COMMIT).
  - Function/macro for bit index r*16+c.
- Sub-module gol_row_next (combinational):
  - Inputs: three 16-bit rows.
  - Output: next 16-bit row, with column wrap.
  - Neighbour count is 4 bits.

Test Plan:
- Reset then blinker: load row 7=0x0070, step -> after 17 cycles rows 6,7,8 = 0x0020 each, others 0, generation_o=1, gen_done_o one pulse; step again -> row 7=0x0070, generation_o=2.
- Block still life: rows 3,4 = 0x0018, run with TICK_CYCLES=40, speed 0 -> gen_done_o every 58 cycles (40 WAIT + 17 COMPUTE/COMMIT + 1 re-entry). Board unchanged after 5 generations, generation_o=5.
- Toroidal wrap: vertical blinker at column 0, rows 15,0,1 (bit 0 set) -> one step gives row 0=0x8003, rows 15 and 1=0.
- Clear mid-compute: step, pulse clear_i on cycle 8 of COMPUTE -> board_o=0, generation_o=0, state IDLE, no gen_done_o.
- Arbitration: while running, pulse step_i and load_i (row 2=0xFFFF) -> both ignored, board follows rule only. Simultaneous clear_i and load_i in IDLE -> board all zero.
- Wrap: force generation to 0xFFFF (65535 steps or a bench preload), step -> generation_o=0x0000, gen_done_o pulses.
